snek_ctrl: RTL



---
 rtl/snek_pkg.sv | 35 +++
 rtl/snek_food_lfsr.sv | 70 +++++++
 rtl/snek_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/snek_pkg.sv
// Shared encodings and defaults for the snake game sequencer and its food placer.
package snek_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;
    localparam int CELL_PX    = 20;

    localparam logic [4:0] FOOD_RST_H = 5'd20;
    localparam logic [4:0] FOOD_RST_V = 5'd11;

    typedef enum logic [2:0] {
        DIR_L    = 3'd0,
        DIR_R    = 3'd1,
        DIR_D    = 3'd2,
        DIR_U    = 3'd3,
        DIR_NONE = 3'd4
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    function automatic dir_e dir_opposite(input dir_e d);
        case (d)
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_L;
            DIR_D:   return DIR_U;
            DIR_U:   return DIR_D;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/snek_food_lfsr.sv
// Food placer: free-running LFSR, one candidate per clk after go, done pulse on accept or after 64 tries.
// Result is valid with done; no backpressure, the caller must take it on the pulse.
module snek_food_lfsr
    import snek_pkg::*;
#(
    parameter int          GRID_W    = GRID_W_DEF,
    parameter int          GRID_H    = GRID_H_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [4:0] head_h,
    input  logic [4:0] head_v,
    output logic       done,
    output logic [4:0] found_h,
    output logic [4:0] found_v
);

    localparam logic [5:0] W6 = 6'(GRID_W);
    localparam logic [5:0] H6 = 6'(GRID_H);

    logic [15:0] lfsr;
    logic        busy;
    logic [5:0]  tries;
    logic        fb;
    logic [4:0]  cand_h;
    logic [4:0]  cand_v;
    logic        accept;

    // x^16 + x^14 + x^13 + x^11
    assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cand_h = lfsr[4:0];
    assign cand_v = lfsr[9:5];
    assign accept = ({1'b0, cand_h} < W6) && ({1'b0, cand_v} < H6) &&
                    !((cand_h == head_h) && (cand_v == head_v));

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr    <= LFSR_SEED;
            busy    <= 1'b0;
            tries   <= '0;
            done    <= 1'b0;
            found_h <= '0;
            found_v <= '0;
        end else begin
            lfsr <= {lfsr[14:0], fb};
            done <= 1'b0;
            if (go) begin
                busy  <= 1'b1;
                tries <= '0;
            end else if (busy) begin
                if (accept) begin
                    done    <= 1'b1;
                    found_h <= cand_h;
                    found_v <= cand_v;
                    busy    <= 1'b0;
                end else if (tries == 6'd63) begin
                    done    <= 1'b1;
                    found_h <= '0;
                    found_v <= '0;
                    busy    <= 1'b0;
                end else begin
                    tries <= tries + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/snek_ctrl.sv
// Snake game sequencer: direction filter, step pacing, wall/body death, eating, score and food placement.
// run/grow_flag/dir update one clk after frame_tick and hold for the frame; no backpressure.
module snek_ctrl
    import snek_pkg::*;
#(
    parameter int          FRAMES_PER_STEP = 8,
    parameter int          GRID_W          = GRID_W_DEF,
    parameter int          GRID_H          = GRID_H_DEF,
    parameter int          MAXLEN          = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    input  logic       start,
    input  logic [4:0] head_h,
    input  logic [4:0] head_v,
    input  logic       body_hit,
    output logic       run,
    output logic       grow_flag,
    output logic [2:0] dir,
    output logic [4:0] food_h,
    output logic [4:0] food_v,
    output logic [7:0] score,
    output logic [1:0] state
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] LEN_MAX  = 8'(MAXLEN);
    localparam logic [4:0] H_LAST   = 5'(GRID_W - 1);
    localparam logic [4:0] V_LAST   = 5'(GRID_H - 1);

    state_e     state_q, state_d;
    dir_e       dir_q, pend_q, sel;
    logic [7:0] len_q, cnt_q;
    logic       hit_q, start_q;
    logic       start_rise, step, wall, move, eat, sel_ok, grow_ok;
    logic       food_done;
    logic [4:0] found_h, found_v;

    assign start_rise = start & ~start_q;
    assign step       = (state_q == ST_PLAY) && frame_tick && (cnt_q == CNT_LAST);
    assign sel_ok     = (sel != DIR_NONE) && (sel != dir_opposite(dir_q));
    assign eat        = move && (head_h == food_h) && (head_v == food_v);
    assign grow_ok    = len_q < LEN_MAX;

    assign dir   = dir_q;
    assign state = state_q;

    always_comb begin
        sel = DIR_NONE;
        if (btn[0])      sel = DIR_L;
        else if (btn[1]) sel = DIR_R;
        else if (btn[2]) sel = DIR_D;
        else if (btn[3]) sel = DIR_U;
    end

    always_comb begin
        wall = 1'b0;
        case (pend_q)
            DIR_L:   wall = (head_h == 5'd0);
            DIR_R:   wall = (head_h == H_LAST);
            DIR_U:   wall = (head_v == 5'd0);
            DIR_D:   wall = (head_v == V_LAST);
            default: wall = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        move    = 1'b0;
        case (state_q)
            ST_IDLE: if (start_rise) state_d = ST_PLAY;
            ST_PLAY: begin
                if (step && (pend_q != DIR_NONE)) begin
                    if (wall || hit_q) state_d = ST_DEAD;
                    else               move    = 1'b1;
                end
            end
            ST_DEAD: if (start_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run       <= 1'b0;
            grow_flag <= 1'b0;
            dir_q     <= DIR_NONE;
            pend_q    <= DIR_NONE;
            food_h    <= FOOD_RST_H;
            food_v    <= FOOD_RST_V;
            score     <= '0;
            len_q     <= 8'd1;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= start;
            // Outputs to the body generator only move on frame boundaries.
            if (frame_tick) begin
                run       <= move;
                grow_flag <= eat && grow_ok;
                if (move) dir_q <= pend_q;
            end
            if (food_done) begin
                food_h <= found_h;
                food_v <= found_v;
            end
            if ((state_q == ST_IDLE) && start_rise) begin
                score <= '0;
                len_q <= 8'd1;
                cnt_q <= '0;
                hit_q <= 1'b0;
            end
            if (state_q == ST_PLAY) begin
                if (frame_tick) cnt_q <= (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
                hit_q <= step ? 1'b0 : (hit_q | body_hit);
                if (sel_ok) pend_q <= sel;
                if (eat) begin
                    if (grow_ok)       len_q <= len_q + 8'd1;
                    if (score != 8'hFF) score <= score + 8'd1;
                end
            end
        end
    end

    snek_food_lfsr #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .LFSR_SEED (LFSR_SEED)
    ) u_food (
        .clk     (clk),
        .reset   (reset),
        .go      (eat),
        .head_h  (head_h),
        .head_v  (head_v),
        .done    (food_done),
        .found_h (found_h),
        .found_v (found_v)
    );

endmodule
